// File: rtl/mac8_feeder_pkg.sv
// Shared definitions for the MAC-array input feeder.
//   state_t      : feeder sequencing states
//   NUM_MACS_DEF : default lane count of the MAC array
//   MAC_LAT_DEF  : default cycles from lane En to Cout update
//   len_width()  : width needed to hold lengths 0..max_len
package mac_feed_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  localparam int NUM_MACS_DEF = 8;
  localparam int MAC_LAT_DEF  = 1;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/mac8_feeder_if.sv
// B-operand stream handshake between the upstream source and the feeder.
//   b_valid : source has an element on b_data
//   b_ready : feeder accepts the element this cycle
//   b_data  : B element
// master = upstream source, slave = feeder.
interface mac8_feeder_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  b_valid;
  logic                  b_ready;
  logic [DATA_WIDTH-1:0] b_data;

  modport master (output b_valid, output b_data, input b_ready);
  modport slave  (input b_valid, input b_data, output b_ready);

endinterface

// File: rtl/mac8_feeder_skew_line.sv
// Skew line generating per-lane A FIFO read enables.
//   clk    : clock
//   clr    : synchronous active-high clear of all taps
//   en_in  : enable pulse stream (En_out of the feeder)
//   taps   : taps[i] = en_in delayed by i cycles; taps[0] is en_in itself
module skew_line #(
  parameter int NUM_MACS = 8
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en_in,
  output logic [NUM_MACS-1:0] taps
);

  logic [NUM_MACS-2:0] sr_q, sr_d;

  always_comb begin
    sr_d    = sr_q << 1;
    sr_d[0] = en_in;
  end

  always_ff @(posedge clk) begin
    if (clr) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign taps = {sr_q, en_in};

endmodule

// File: rtl/mac8_feeder.sv
// Transmit-side sequencer for the 8-lane MAC array.
//   clk, rst : clock, synchronous active-high reset
//   start,len: job request (taken only in IDLE) and vector length
//   busy     : job in progress; done: one-cycle completion pulse
//   b_if     : B-operand stream (valid/ready), feeder is the slave
//   En_out, Clr_out, b_out : registered drive of the array's En/Clr/B inputs
//   a_rd_en  : per-lane A FIFO read enables, En_out skewed by lane index
module mac8_feeder
  import mac_feed_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_MACS   = NUM_MACS_DEF,
  parameter  int MAC_LAT    = MAC_LAT_DEF,
  parameter  int MAX_LEN    = 255,
  localparam int LEN_W      = len_width(MAX_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  output logic                  busy,
  output logic                  done,
  mac8_feeder_if.slave          b_if,
  output logic                  En_out,
  output logic                  Clr_out,
  output logic [DATA_WIDTH-1:0] b_out,
  output logic [NUM_MACS-1:0]   a_rd_en
);

  localparam int DRAIN_CYC = NUM_MACS + MAC_LAT;
  localparam int DRAIN_W   = $clog2(DRAIN_CYC + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYC);

  state_t                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      beat_q, beat_d;
  logic [DRAIN_W-1:0]    drain_q, drain_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  clr_q, clr_d;
  logic                  en_q, en_d;
  logic [DATA_WIDTH-1:0] bout_q, bout_d;
  logic                  hs;

  assign b_if.b_ready = (state_q == STREAM);
  assign hs           = b_if.b_valid && b_if.b_ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    clr_d   = 1'b0;
    en_d    = 1'b0;
    bout_d  = bout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          beat_d  = '0;
          busy_d  = 1'b1;
          clr_d   = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        // Zero-length jobs enter DRAIN one cycle after their reference
        // (Clr) cycle, streamed jobs in the cycle of the last En, so the
        // empty job drains one cycle shorter to keep done at T+DRAIN_CYC+1.
        if (len_q == '0) begin
          drain_d = DRAIN_LOAD - DRAIN_W'(1);
          state_d = DRAIN;
        end else begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (hs) begin
          en_d   = 1'b1;
          bout_d = b_if.b_data;
          if (beat_q == len_q - LEN_W'(1)) begin
            beat_d  = '0;
            drain_d = DRAIN_LOAD;
            state_d = DRAIN;
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      bout_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
      en_q    <= en_d;
      bout_q  <= bout_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign Clr_out = clr_q;
  assign En_out  = en_q;
  assign b_out   = bout_q;

  skew_line #(
    .NUM_MACS(NUM_MACS)
  ) u_skew (
    .clk  (clk),
    .clr  (rst),
    .en_in(en_q),
    .taps (a_rd_en)
  );

endmodule

// File: tb/tb_mac8_feeder.sv
// Scoreboard bench for mac8_feeder: each job's expected events are derived
// from the job rules (Clr at s+1, beats on the first len valid cycles from
// s+2, En one cycle after each beat, done at T+NUM_MACS+MAC_LAT+1) and
// queued; a negedge monitor pops and compares as the DUT shows them.
module tb_mac8_feeder;

  localparam int DW    = 8;
  localparam int NM    = 8;
  localparam int ML    = 1;
  localparam int MAXL  = 255;
  localparam int LW    = 8;
  localparam int DRAIN = NM + ML + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] len;
  logic          busy, done, En_out, Clr_out;
  logic [DW-1:0] b_out;
  logic [NM-1:0] a_rd_en;

  mac8_feeder_if #(.DATA_WIDTH(DW)) bif ();

  mac8_feeder #(
    .DATA_WIDTH(DW),
    .NUM_MACS  (NM),
    .MAC_LAT   (ML),
    .MAX_LEN   (MAXL)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .len    (len),
    .busy   (busy),
    .done   (done),
    .b_if   (bif),
    .En_out (En_out),
    .Clr_out(Clr_out),
    .b_out  (b_out),
    .a_rd_en(a_rd_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } ev_t;

  ev_t q_en[$];
  int  q_clr[$];
  int  q_done[$];
  bit  en_set[int];
  bit  exp_busy[int];
  bit  exp_ready[int];

  int n_tests = 0;
  int n_fail  = 0;

  // Job configuration, set before each run_job call
  bit            vpat[$];
  logic [DW-1:0] elems[$];
  int            pulses[$];
  int            abort_k;
  int            vprob;
  bit            rand_starts;

  task automatic check(input bit ok, input string name, input longint act, input longint exp_v);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
    end
  endtask

  task automatic clear_cfg();
    vpat.delete();
    elems.delete();
    pulses.delete();
    abort_k     = -1;
    vprob       = 100;
    rand_starts = 1'b0;
  endtask

  function automatic bit is_pulse(input int k);
    foreach (pulses[i]) if (pulses[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  // Build the expected events for one job starting this cycle, then drive it.
  task automatic run_job(input int jlen);
    int s, lim, beats, k, last_en, t, d, k_end, idx;
    bit hs[$];
    bit st;
    s   = cyc;
    lim = (abort_k >= 0) ? s + abort_k : 32'h7fffffff;
    while (elems.size() < jlen + 4) elems.push_back(DW'($urandom));
    beats   = 0;
    k       = 0;
    last_en = -1;
    while (beats < jlen || k < 2) begin
      if (k >= vpat.size()) vpat.push_back($urandom_range(0, 99) < vprob);
      if (k >= 2 && beats < jlen) begin
        if (s + k <= lim) exp_ready[s + k] = 1'b1;
        if (vpat[k]) begin
          hs.push_back(1'b1);
          if (s + k + 1 <= lim) begin
            q_en.push_back('{cyc: s + k + 1, data: elems[beats]});
            en_set[s + k + 1] = 1'b1;
          end
          last_en = s + k + 1;
          beats++;
        end else begin
          hs.push_back(1'b0);
        end
      end else begin
        hs.push_back(1'b0);
      end
      k++;
    end
    t = (jlen == 0) ? s + 1 : last_en;
    d = t + DRAIN;
    if (s + 1 <= lim) q_clr.push_back(s + 1);
    for (int c2 = s + 1; c2 <= d; c2++) if (c2 <= lim) exp_busy[c2] = 1'b1;
    if (d <= lim) q_done.push_back(d);
    k_end = (abort_k >= 0) ? abort_k : d - s;
    while (vpat.size() <= k_end) vpat.push_back($urandom_range(0, 99) < vprob);
    while (hs.size() <= k_end) hs.push_back(1'b0);

    idx = 0;
    for (int kk = 0; kk <= k_end; kk++) begin
      st = (kk == 0) || is_pulse(kk) || (rand_starts && kk > 0 && $urandom_range(0, 9) == 0);
      start       = st;
      len         = (kk == 0) ? LW'(jlen) : (is_pulse(kk) ? LW'(9) : LW'($urandom));
      bif.b_valid = vpat[kk];
      bif.b_data  = (idx < elems.size()) ? elems[idx] : DW'($urandom);
      rst         = (kk == abort_k);
      @(posedge clk); #1;
      if (hs[kk]) idx++;
    end
    start       = 1'b0;
    bif.b_valid = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor
  int            mc;
  int            rlast = -100;
  logic [DW-1:0] hold  = '0;
  logic [NM-1:0] exp_rd;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      mc = cyc;
      while (q_clr.size() > 0 && q_clr[0] < mc) begin
        check(1'b0, "clr_missing", 0, q_clr[0]);
        q_clr.delete(0);
      end
      while (q_en.size() > 0 && q_en[0].cyc < mc) begin
        check(1'b0, "en_missing", 0, q_en[0].cyc);
        q_en.delete(0);
      end
      while (q_done.size() > 0 && q_done[0] < mc) begin
        check(1'b0, "done_missing", 0, q_done[0]);
        q_done.delete(0);
      end

      if (Clr_out) begin
        if (q_clr.size() == 0) check(1'b0, "clr_unexpected", mc, -1);
        else begin
          check(q_clr[0] == mc, "clr_cycle", mc, q_clr[0]);
          if (q_clr[0] == mc) q_clr.delete(0);
        end
      end

      if (En_out) begin
        if (q_en.size() == 0) check(1'b0, "en_unexpected", mc, -1);
        else begin
          check(q_en[0].cyc == mc, "en_cycle", mc, q_en[0].cyc);
          if (q_en[0].cyc == mc) begin
            check(b_out == q_en[0].data, "en_data", b_out, q_en[0].data);
            hold = q_en[0].data;
            q_en.delete(0);
          end
        end
      end else begin
        check(b_out == hold, "b_out_hold", b_out, hold);
      end

      if (done) begin
        if (q_done.size() == 0) check(1'b0, "done_unexpected", mc, -1);
        else begin
          check(q_done[0] == mc, "done_cycle", mc, q_done[0]);
          if (q_done[0] == mc) q_done.delete(0);
        end
      end

      check(busy == exp_busy.exists(mc), "busy", busy, exp_busy.exists(mc));
      check(bif.b_ready == exp_ready.exists(mc), "b_ready", bif.b_ready, exp_ready.exists(mc));

      for (int i = 0; i < NM; i++) exp_rd[i] = en_set.exists(mc - i) && (mc - i > rlast);
      check(a_rd_en == exp_rd, "a_rd_en", a_rd_en, exp_rd);

      if (rst) begin
        rlast = mc;
        hold  = '0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    len         = '0;
    bif.b_valid = 1'b0;
    bif.b_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic: len 4, data 1..4, valid held high
    clear_cfg();
    elems = '{8'd1, 8'd2, 8'd3, 8'd4};
    run_job(4);
    idle(1);

    // Bubbles: valid only at job cycles 2, 4, 7
    clear_cfg();
    vpat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vprob = 0;
    for (int i = 8; i < 40; i++) vpat.push_back(1'b0);
    run_job(3);
    idle(2);

    // Zero length, random valid that must never be taken
    clear_cfg();
    vprob = 50;
    run_job(0);

    // Ignored start pulses during a job, including the done cycle
    clear_cfg();
    pulses = '{4, 16};
    run_job(4);
    idle(2);

    // Reset mid-stream, then a fresh job two cycles later
    clear_cfg();
    abort_k = 5;
    run_job(4);
    idle(2);
    clear_cfg();
    run_job(4);

    // Maximum length, continuous valid
    clear_cfg();
    run_job(MAXL);
    idle(1);

    // Randomized jobs with bubbles and stray start requests
    for (int j = 0; j < 25; j++) begin
      clear_cfg();
      vprob       = $urandom_range(25, 100);
      rand_starts = 1'b1;
      run_job((j % 8 == 7) ? int'($urandom_range(200, MAXL)) : int'($urandom_range(0, 12)));
      idle($urandom_range(0, 3));
    end

    idle(4);
    check(q_en.size() == 0, "en_leftover", q_en.size(), 0);
    check(q_clr.size() == 0, "clr_leftover", q_clr.size(), 0);
    check(q_done.size() == 0, "done_leftover", q_done.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
